// File: rtl/axi_lite_bram_pkg.sv
// rtl/axi_lite_bram_pkg.sv - response codes, FSM/grant types and address helper for the AXI-Lite BRAM controller
package axi_lite_bram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_RESP,
        ST_RD_PIPE,
        ST_RD_RESP
    } state_t;

    typedef enum logic {
        GRANT_READ,
        GRANT_WRITE
    } grant_t;

    // Word indices are carried at a fixed wide width so range checks never truncate.
    localparam int unsigned IDX_W = 64;

    function automatic logic [IDX_W-1:0] word_index(input logic [IDX_W-1:0] addr,
                                                    input int unsigned       lsb);
        return addr >> lsb;
    endfunction

endpackage

// File: rtl/bram_bytewise_sp.sv
// rtl/bram_bytewise_sp.sv - single-port RAM with per-byte write enables and a 1- or 2-stage read pipeline
module bram_bytewise_sp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    en_i,
    input  logic [DATA_WIDTH/8-1:0] we_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // No reset on the array or read register so the tools can map this onto block RAM.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (en_i) begin
            rd_q <= mem_q[addr_i];
        end
    end

    generate
        if (RD_LATENCY > 1) begin : g_pipe
            logic [DATA_WIDTH-1:0] pipe_q;
            always_ff @(posedge clk_i) begin
                pipe_q <= rd_q;
            end
            assign rdata_o = pipe_q;
        end else begin : g_direct
            assign rdata_o = rd_q;
        end
    endgenerate

endmodule

// File: rtl/axi_lite_bram_ctrl.sv
// rtl/axi_lite_bram_ctrl.sv - AXI4-Lite slave fronting a byte-writable BRAM with read/write arbitration
module axi_lite_bram_ctrl
    import axi_lite_bram_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int MEM_DEPTH          = 1024,
    parameter int RD_LATENCY         = 1
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int unsigned NB       = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(NB);
    localparam int unsigned RAM_AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_t                  state_q;
    grant_t                  last_grant_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic                    rvalid_q;
    logic [1:0]              rresp_q;
    logic                    rerr_q;

    logic [IDX_W-1:0]        aw_idx;
    logic [IDX_W-1:0]        ar_idx;
    logic                    aw_in_range;
    logic                    ar_in_range;
    logic                    wr_req;
    logic                    rd_req;
    logic                    grant_wr;
    logic                    grant_rd;

    logic                    ram_en;
    logic [NB-1:0]           ram_we;
    logic [RAM_AW-1:0]       ram_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] ram_rdata;

    logic                    unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign aw_idx      = word_index(IDX_W'(S_AXI_AWADDR), ADDR_LSB);
    assign ar_idx      = word_index(IDX_W'(S_AXI_ARADDR), ADDR_LSB);
    assign aw_in_range = aw_idx < IDX_W'(MEM_DEPTH);
    assign ar_in_range = ar_idx < IDX_W'(MEM_DEPTH);

    // A write needs both AW and W present; partial writes are never half-accepted.
    assign wr_req   = S_AXI_ARESETN && (state_q == ST_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_req   = S_AXI_ARESETN && (state_q == ST_IDLE) && S_AXI_ARVALID;
    assign grant_wr = wr_req && (!rd_req || (last_grant_q == GRANT_READ));
    assign grant_rd = rd_req && !grant_wr;

    assign S_AXI_AWREADY = grant_wr;
    assign S_AXI_WREADY  = grant_wr;
    assign S_AXI_ARREADY = grant_rd;

    assign ram_en   = grant_rd && ar_in_range;
    assign ram_we   = (grant_wr && aw_in_range) ? S_AXI_WSTRB : '0;
    assign ram_addr = grant_wr ? aw_idx[RAM_AW-1:0] : ar_idx[RAM_AW-1:0];

    bram_bytewise_sp #(
        .DATA_WIDTH (C_S_AXI_DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .ADDR_W     (RAM_AW),
        .RD_LATENCY (RD_LATENCY)
    ) u_ram (
        .clk_i   (S_AXI_ACLK),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (S_AXI_WDATA),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_READ;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            rvalid_q     <= 1'b0;
            rresp_q      <= RESP_OKAY;
            rerr_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_wr) begin
                        bvalid_q <= 1'b1;
                        bresp_q  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
                        state_q  <= ST_WR_RESP;
                    end else if (grant_rd) begin
                        rresp_q <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                        rerr_q  <= !ar_in_range;
                        if (RD_LATENCY > 1) begin
                            state_q <= ST_RD_PIPE;
                        end else begin
                            rvalid_q <= 1'b1;
                            state_q  <= ST_RD_RESP;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q     <= 1'b0;
                        last_grant_q <= GRANT_WRITE;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_RD_PIPE: begin
                    rvalid_q <= 1'b1;
                    state_q  <= ST_RD_RESP;
                end
                ST_RD_RESP: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q     <= 1'b0;
                        last_grant_q <= GRANT_READ;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RRESP  = rresp_q;
    // Out-of-range reads never enable the RAM, so their data is forced to zero here.
    assign S_AXI_RDATA  = (rvalid_q && !rerr_q) ? ram_rdata : '0;

endmodule
